// File: rtl/lisnoc_wormhole_switch_arbiter.sv
// ---------------------------------------------------------------------------
// lisnoc_wormhole_switch_arbiter
//   Output-port arbiter of the lisnoc router. Selects one of `ports` input
//   requesters with round-robin fairness. The grant stays locked from a
//   HEADER flit to its LAST flit, so packets never interleave. Accepted flits
//   go into a small FIFO that drains through a valid/ready handshake.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   flit_i     concatenated input flits, port p at [(p+1)*W-1 : p*W]
//   request_i  per-port "flit available"
//   read_i     one-hot (or zero) pop strobe to the granted input
//   flit_o     head entry of the output queue
//   valid_o    output queue not empty
//   ready_o    downstream takes flit_o this cycle
// ---------------------------------------------------------------------------
module lisnoc_wormhole_switch_arbiter #(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int ports           = 5,
    parameter int buffer_depth    = 2
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [ports*(flit_data_width+flit_type_width)-1:0]    flit_i,
    input  logic [ports-1:0]                                      request_i,
    output logic [ports-1:0]                                      read_i,
    output logic [flit_data_width+flit_type_width-1:0]            flit_o,
    output logic                                                  valid_o,
    input  logic                                                  ready_o
);

    localparam int FLIT_W = flit_data_width + flit_type_width;
    localparam int PORT_W = (ports > 1) ? $clog2(ports) : 1;
    localparam int CNT_W  = $clog2(buffer_depth + 1);
    localparam int PTR_W  = (buffer_depth > 1) ? $clog2(buffer_depth) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(buffer_depth - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(buffer_depth);

    localparam logic [flit_type_width-1:0] TYPE_PAYLOAD = flit_type_width'(2'b00);
    localparam logic [flit_type_width-1:0] TYPE_HEADER  = flit_type_width'(2'b01);
    localparam logic [flit_type_width-1:0] TYPE_LAST    = flit_type_width'(2'b10);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [PORT_W-1:0]      last_grant_r;
    logic [PORT_W-1:0]      locked_port_r;
    logic                   err_r;

    logic [FLIT_W-1:0]      mem_r [buffer_depth];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_next_s;
    logic                   valid_r;

    logic [PORT_W-1:0]      chosen_s;
    logic [PORT_W-1:0]      cand_s;
    logic                   found_s;
    logic [PORT_W-1:0]      grant_port_s;
    logic [ports-1:0]       read_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   space_s;
    logic [FLIT_W-1:0]      push_flit_s;
    logic [flit_type_width-1:0] push_type_s;

    // Circular pointer advance that wraps at the configured queue depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return '0;
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign pop_s   = valid_r & ready_o;
    // A full queue still has room when its head leaves in the same cycle.
    assign space_s = (count_r < CNT_FULL) | pop_s;

    // Round-robin pick: first requester after the last granted port.
    always_comb begin
        chosen_s = last_grant_r;
        found_s  = 1'b0;
        cand_s   = '0;
        for (int i = 1; i <= ports; i++) begin
            cand_s = PORT_W'((int'(last_grant_r) + i) % ports);
            if (!found_s && request_i[cand_s]) begin
                found_s  = 1'b1;
                chosen_s = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: HEADER opens a wormhole lock, LAST closes it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (push_s && (push_type_s == TYPE_HEADER)) begin
                    state_next_s = ST_LOCKED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (push_s && (push_type_s == TYPE_LAST)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: grant strobe and the port whose flit is pushed.
    always_comb begin
        read_s       = '0;
        grant_port_s = chosen_s;
        case (state_r)
            ST_IDLE: begin
                grant_port_s = chosen_s;
                if (found_s && space_s) begin
                    read_s[chosen_s] = 1'b1;
                end else begin
                    read_s = '0;
                end
            end
            ST_LOCKED: begin
                grant_port_s = locked_port_r;
                if (request_i[locked_port_r] && space_s) begin
                    read_s[locked_port_r] = 1'b1;
                end else begin
                    read_s = '0;
                end
            end
            default: begin
                read_s       = '0;
                grant_port_s = chosen_s;
            end
        endcase
    end

    // Gate the strobe with reset so no input is popped while reset is held.
    assign read_i      = rst ? read_s : '0;
    assign push_s      = |read_i;
    assign push_flit_s = flit_i[grant_port_s*FLIT_W +: FLIT_W];
    assign push_type_s = push_flit_s[FLIT_W-1 -: flit_type_width];

    // Arbitration bookkeeping: priority pointer, lock owner, sticky protocol error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r  <= PORT_W'(ports - 1);
            locked_port_r <= '0;
            err_r         <= 1'b0;
        end else if (push_s && (state_r == ST_IDLE)) begin
            last_grant_r <= chosen_s;
            if (push_type_s == TYPE_HEADER) begin
                locked_port_r <= chosen_s;
            end else begin
                locked_port_r <= locked_port_r;
            end
            // PAYLOAD/LAST outside a packet is forwarded but flagged.
            if ((push_type_s == TYPE_PAYLOAD) || (push_type_s == TYPE_LAST)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end else begin
            last_grant_r  <= last_grant_r;
            locked_port_r <= locked_port_r;
            err_r         <= err_r;
        end
    end

    // Occupancy after this cycle's push and pop.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Output FIFO storage, pointers and the registered valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < buffer_depth; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_flit_s;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != '0);
        end
    end

    assign flit_o  = mem_r[rd_ptr_r];
    assign valid_o = valid_r;

endmodule
